// File: rtl/serial_tx_pkg.sv
// Shared types and width helpers for the serial transmit controller.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        LATCH = 2'b10
    } tx_state_t;

    localparam int MIN_CNT_W = 1;

    // Counter width that still holds n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : MIN_CNT_W;
    endfunction

endpackage

// File: rtl/serial_tx_tick.sv
// Down-counting divider: tick is high for one cycle out of every CLK_DIV.
module serial_tx_tick
    import serial_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int DW = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clear || div_cnt == '0) begin
            div_cnt <= RELOAD;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign tick = (div_cnt == '0);

endmodule

// File: rtl/serial_tx_ctrl.sv
// Parallel-to-serial transmitter: MSB-first on a divided sclk, then a latch strobe.
//   state | meaning
//   IDLE  | waiting for start, divider held at reload, sclk/slatch low
//   SHIFT | shifting bits out, phase 0 = sclk low, phase 1 = sclk high
//   LATCH | slatch high for one divider period, then done pulse in IDLE
module serial_tx_ctrl
    import serial_tx_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             sdata,
    output logic             slatch
);

    localparam int BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             phase;
    logic             tick;

    // Divider is held in reload while idle, so the first tick lands CLK_DIV cycles after start.
    serial_tx_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .tick  (tick)
    );

    assign sdata = shreg[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            slatch  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= data;
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                        sclk    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            phase <= 1'b1;
                            sclk  <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            sclk  <= 1'b0;
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                slatch  <= 1'b1;
                                state   <= LATCH;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        slatch <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    sclk   <= 1'b0;
                    slatch <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Directed bench for serial_tx_ctrl: default instance plus a WIDTH=8, CLK_DIV=1 instance.
module tb_serial_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] data;
    logic        busy, done, sclk, sdata, slatch;

    logic        rst8, start8;
    logic [7:0]  data8;
    logic        busy8, done8, sclk8, sdata8, slatch8;

    int checks = 0;
    int errors = 0;

    logic [63:0] s_stream;
    int s_nrise, s_first_rise, s_latch_first, s_latch_cnt, s_latch_sdata_bad;
    int s_done_first, s_done_cnt, s_busy_cnt, s_busy_low_first, s_busy_low_cnt;

    always #5 clk = ~clk;

    serial_tx_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .data(data),
        .busy(busy), .done(done), .sclk(sclk), .sdata(sdata), .slatch(slatch)
    );

    serial_tx_ctrl #(.WIDTH(8), .CLK_DIV(1)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .data(data8),
        .busy(busy8), .done(done8), .sclk(sclk8), .sdata(sdata8), .slatch(slatch8)
    );

    // Pulse (or hold) start so that it is sampled at edge E0; returns in cycle 0.
    task automatic launch(input logic [15:0] d, input bit hold);
        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Observe ncyc cycles from cycle 0, optionally injecting extra start pulses or a data change.
    task automatic capture(input int ncyc, input int inj1, input int inj2,
                           input logic [15:0] injdata, input int dchg, input logic [15:0] dval);
        logic prev;
        prev = 1'b0;
        s_stream = '0; s_nrise = 0; s_first_rise = -1;
        s_latch_first = -1; s_latch_cnt = 0; s_latch_sdata_bad = 0;
        s_done_first = -1; s_done_cnt = 0; s_busy_cnt = 0;
        s_busy_low_first = -1; s_busy_low_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if ((inj1 >= 0 && c == inj1) || (inj2 >= 0 && c == inj2)) begin
                start = 1'b1;
                data  = injdata;
            end else if ((inj1 >= 0 && c == inj1 + 1) || (inj2 >= 0 && c == inj2 + 1)) begin
                start = 1'b0;
            end
            if (c == dchg) data = dval;
            if (sclk && !prev) begin
                s_stream = {s_stream[62:0], sdata};
                if (s_nrise == 0) s_first_rise = c;
                s_nrise++;
            end
            prev = sclk;
            if (slatch) begin
                if (s_latch_cnt == 0) s_latch_first = c;
                s_latch_cnt++;
                if (sdata !== 1'b0) s_latch_sdata_bad++;
            end
            if (done) begin
                if (s_done_cnt == 0) s_done_first = c;
                s_done_cnt++;
            end
            if (busy) s_busy_cnt++;
            else begin
                if (s_busy_low_cnt == 0) s_busy_low_first = c;
                s_busy_low_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; rst8 = 1'b1; start = 1'b0; start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (sclk !== 1'b0)   begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (sdata !== 1'b0)  begin errors++; $display("FAIL reset_sdata: got %b expected 0", sdata); end
        checks++; if (slatch !== 1'b0) begin errors++; $display("FAIL reset_slatch: got %b expected 0", slatch); end
        rst = 1'b0; rst8 = 1'b0;
    endtask

    task automatic test_basic();
        launch(16'hA5C3, 1'b0);
        capture(140, -1, -1, 16'h0, -1, 16'h0);
        checks++; if (s_stream[15:0] !== 16'hA5C3) begin errors++; $display("FAIL basic_stream: got %h expected a5c3", s_stream[15:0]); end
        checks++; if (s_nrise !== 16)       begin errors++; $display("FAIL basic_nrise: got %0d expected 16", s_nrise); end
        checks++; if (s_first_rise !== 4)   begin errors++; $display("FAIL basic_first_rise: got %0d expected 4", s_first_rise); end
        checks++; if (s_latch_first !== 128) begin errors++; $display("FAIL basic_latch_first: got %0d expected 128", s_latch_first); end
        checks++; if (s_latch_cnt !== 4)    begin errors++; $display("FAIL basic_latch_len: got %0d expected 4", s_latch_cnt); end
        checks++; if (s_latch_sdata_bad !== 0) begin errors++; $display("FAIL basic_latch_sdata: got %0d nonzero cycles expected 0", s_latch_sdata_bad); end
        checks++; if (s_done_first !== 132) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 132", s_done_first); end
        checks++; if (s_done_cnt !== 1)     begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", s_done_cnt); end
        checks++; if (s_busy_cnt !== 132)   begin errors++; $display("FAIL basic_busy_len: got %0d expected 132", s_busy_cnt); end
        checks++; if (s_busy_low_first !== 132) begin errors++; $display("FAIL basic_busy_end: got %0d expected 132", s_busy_low_first); end
    endtask

    task automatic test_ignore_start();
        launch(16'hA5C3, 1'b0);
        capture(140, 10, 100, 16'h1234, 50, 16'hFFFF);
        checks++; if (s_stream[15:0] !== 16'hA5C3) begin errors++; $display("FAIL ignore_stream: got %h expected a5c3", s_stream[15:0]); end
        checks++; if (s_done_cnt !== 1)   begin errors++; $display("FAIL ignore_done_cnt: got %0d expected 1", s_done_cnt); end
        checks++; if (s_busy_cnt !== 132) begin errors++; $display("FAIL ignore_busy_len: got %0d expected 132", s_busy_cnt); end
    endtask

    task automatic test_back_to_back();
        launch(16'hFFFF, 1'b1);
        capture(265, -1, -1, 16'h0, 50, 16'h0001);
        checks++; if (s_stream[31:0] !== 32'hFFFF_0001) begin errors++; $display("FAIL b2b_stream: got %h expected ffff0001", s_stream[31:0]); end
        checks++; if (s_nrise !== 32)          begin errors++; $display("FAIL b2b_nrise: got %0d expected 32", s_nrise); end
        checks++; if (s_busy_low_cnt !== 1)    begin errors++; $display("FAIL b2b_gap_len: got %0d expected 1", s_busy_low_cnt); end
        checks++; if (s_busy_low_first !== 132) begin errors++; $display("FAIL b2b_gap_cycle: got %0d expected 132", s_busy_low_first); end
        checks++; if (s_done_first !== 132)    begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 132", s_done_first); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        launch(16'hA5C3, 1'b0);
        for (int c = 0; c <= 50; c++) begin
            @(negedge clk);
            if (c == 50) rst = 1'b1;
        end
        @(negedge clk);
        checks++; if ({busy, done, sclk, sdata, slatch} !== 5'b0) begin errors++; $display("FAIL midrst_outputs: got %b expected 00000", {busy, done, sclk, sdata, slatch}); end
        rst = 1'b0;
        capture(200, -1, -1, 16'h0, -1, 16'h0);
        checks++; if (s_latch_cnt !== 0) begin errors++; $display("FAIL midrst_no_latch: got %0d expected 0", s_latch_cnt); end
        checks++; if (s_done_cnt !== 0)  begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", s_done_cnt); end
        launch(16'h3C5A, 1'b0);
        capture(140, -1, -1, 16'h0, -1, 16'h0);
        checks++; if (s_stream[15:0] !== 16'h3C5A) begin errors++; $display("FAIL midrst_restart_stream: got %h expected 3c5a", s_stream[15:0]); end
        checks++; if (s_done_first !== 132) begin errors++; $display("FAIL midrst_restart_done: got %0d expected 132", s_done_first); end
    endtask

    task automatic test_reset_vs_start();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; data = 16'hFFFF;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_prio_busy: got %b expected 0", busy); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_prio_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_div1();
        logic [7:0] bits;
        logic       prev;
        int sclk_bad, nrise, latch_first, latch_cnt, done_first, busy_cnt;
        bits = '0; prev = 1'b0;
        sclk_bad = 0; nrise = 0; latch_first = -1; latch_cnt = 0; done_first = -1; busy_cnt = 0;
        @(negedge clk);
        start8 = 1'b1; data8 = 8'h81;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        data8  = 8'h00;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (c < 16 && sclk8 !== c[0]) sclk_bad++;
            if (sclk8 && !prev) begin bits = {bits[6:0], sdata8}; nrise++; end
            prev = sclk8;
            if (slatch8) begin if (latch_cnt == 0) latch_first = c; latch_cnt++; end
            if (done8 && done_first < 0) done_first = c;
            if (busy8) busy_cnt++;
        end
        checks++; if (sclk_bad !== 0)   begin errors++; $display("FAIL div1_sclk_toggle: got %0d bad cycles expected 0", sclk_bad); end
        checks++; if (bits !== 8'h81 || nrise !== 8) begin errors++; $display("FAIL div1_stream: got %h/%0d expected 81/8", bits, nrise); end
        checks++; if (latch_first !== 16 || latch_cnt !== 1) begin errors++; $display("FAIL div1_latch: got %0d/%0d expected 16/1", latch_first, latch_cnt); end
        checks++; if (done_first !== 17) begin errors++; $display("FAIL div1_done: got %0d expected 17", done_first); end
        checks++; if (busy_cnt !== 17)   begin errors++; $display("FAIL div1_busy_len: got %0d expected 17", busy_cnt); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data = '0;
        rst8 = 1'b1; start8 = 1'b0; data8 = '0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_reset_vs_start();
        test_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
